// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and constants for the data-memory responder
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int WORD_BYTES = 4;

  // An access is legal only when word aligned and inside the array.
  function automatic logic dmem_addr_err(input logic [31:0] addr, input int depth_words);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(depth_words));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core-side request/response bus of the data-memory responder
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_array.sv
// rtl/dmem_responder_array.sv - word storage with byte-enabled synchronous write and synchronous read
module dmem_array
  import riscv_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic                  re,
  input  logic [AW-1:0]         idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (we && be[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder with error checking
// DMEM_BYTE_EN: when defined, stores honour req_be; otherwise every store writes the full word.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             srst_n,
  dmem_responder_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, enter_resp, rsp_hs;

  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic        cur_we, cur_err;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  wr_be;

  logic        rsp_err_q, load_ok_q;
  logic        arr_we;
  logic [31:0] arr_rdata;

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    rsp_hs     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, so use the live request.
  assign cur_we    = (state_q == IDLE) ? bus.req_we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign cur_err   = dmem_addr_err(cur_addr, DEPTH_WORDS);

`ifdef DMEM_BYTE_EN
  logic [3:0] be_q;

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      be_q <= 4'd0;
    end else if (accept) begin
      be_q <= bus.req_be;
    end
  end

  assign wr_be = (state_q == IDLE) ? bus.req_be : be_q;
`else
  assign wr_be = 4'hF;
`endif

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_err_q <= 1'b0;
      load_ok_q <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (enter_resp) begin
        rsp_err_q <= cur_err;
        load_ok_q <= !cur_we && !cur_err;
      end else if (rsp_hs) begin
        rsp_err_q <= 1'b0;
        load_ok_q <= 1'b0;
      end
    end
  end

  // srst_n gate keeps a store from committing while reset is held.
  assign arr_we = enter_resp && cur_we && !cur_err && srst_n;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .be   (wr_be),
    .re   (enter_resp),
    .idx  (cur_addr[AW+1:2]),
    .wdata(cur_wdata),
    .rdata(arr_rdata)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = load_ok_q ? arr_rdata : 32'd0;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words of storage (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states between request acceptance and response (0..15).
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk  input  1  clock, rising edge; srst_n  input  1  asynchronous reset, active low.
REQ-004 SHALL provide port req_valid  input  1  core request present.
REQ-005 SHALL provide port req_ready  output  1  responder can accept a request.
REQ-006 SHALL provide port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL provide port req_addr  input  32  byte address.
REQ-008 SHALL provide port req_wdata  input  32  store data.
REQ-009 SHALL provide port req_be  input  4  byte enables for stores.
REQ-010 SHALL provide port rsp_valid  output  1  response present.
REQ-011 SHALL provide port rsp_ready  input  1  core accepts the response.
REQ-012 SHALL provide port rsp_rdata  output  32  load data (0 for stores and errors).
REQ-013 SHALL provide port rsp_err  output  1  access was misaligned or out of range.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 SHALL accept a request on a rising edge where req_valid && req_ready, and SHALL register we/addr/wdata/be on that edge.
REQ-016 SHALL leave IDLE on acceptance for WAIT if WAIT_CYCLES>0, else for RESP; it SHALL stay in IDLE otherwise.
REQ-017 SHALL load a down-counter with WAIT_CYCLES-1 on entering WAIT, decrement it each cycle, and go to RESP on the edge where it is 0.
REQ-018 SHALL perform the access on the edge entering RESP: a store writes the array, a load captures the word into rsp_rdata.
REQ-019 SHALL make rsp_valid rise exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_valid && rsp_ready, then return to IDLE.
REQ-021 SHALL NOT accept a new request on the response handshake edge; req_ready rises the following cycle.
REQ-022 SHALL treat addr[1:0]!=0, or a word index >= DEPTH_WORDS, as an error: rsp_err=1, rsp_rdata=0, no array write, same latency.
REQ-023 SHALL return rsp_rdata=0 for stores.
REQ-024 SHALL index the array with word index = addr[31:2] with no wrap-around; upper bits beyond range produce an error per REQ-022.
REQ-025 SHALL ignore req_valid outside IDLE; the request is held by the core and accepted later.

Reset
REQ-026 SHALL put the FSM in IDLE and clear the counter, req_ready(1 after reset release), rsp_valid(0), rsp_rdata(0) and rsp_err(0) when srst_n is asserted.
REQ-027 SHALL NOT clear array contents on reset.
REQ-028 SHALL abort an in-flight access when reset is asserted in WAIT or RESP; a store not yet committed SHALL NOT be written.

Configuration
REQ-029 SHALL honour macro DMEM_BYTE_EN: when defined, stores write only the bytes with req_be[i]=1; when undefined, req_be is ignored and every store writes all 4 bytes.

Structure
REQ-030 SHALL place the state enum dmem_state_e (IDLE, WAIT, RESP) and the constant WORD_BYTES=4 in the shared package riscv_pkg.
REQ-031 SHALL place storage in one sub-module, dmem_array: synchronous write with byte-enable and synchronous read, no reset.

Verification
REQ-032 SHALL cover store then load: store 0xDEADBEEF to 0x10, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after each accept (WAIT_CYCLES=2).
REQ-033 SHALL cover a misaligned access: load 0x13 -> rsp_err=1, rsp_rdata=0; a following load of 0x10 is unchanged.
REQ-034 SHALL cover an out-of-range access: store to 0x400 (DEPTH_WORDS=256) -> rsp_err=1, and no word of the array is modified.
REQ-035 SHALL cover back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata are stable, req_ready=0 throughout, and req_ready=1 one cycle after the handshake.
REQ-036 SHALL cover byte enables: with DMEM_BYTE_EN, store 0x11223344 with be=0b0101 over 0xFFFFFFFF -> load returns 0xFF22FF44; without the macro -> 0x11223344.
REQ-037 SHALL cover reset mid-operation: assert srst_n low during WAIT of a store to 0x20 holding 0xA5A5A5A5 -> after release, rsp_valid=0, req_ready=1, and a load of 0x20 returns 0xA5A5A5A5.
